// File: rtl/max_unpool_dim_scatter.sv
// Max-unpool scatter: expands one {value, index} record into a dense row of
// DIM_SIZE elements, value at the recorded index and FILL everywhere else.
module max_unpool_dim_scatter #(
    parameter int unsigned        DATA_W   = 32,
    parameter int unsigned        DIM_SIZE = 16,
    parameter int unsigned        IDX_W    = (DIM_SIZE > 1) ? $clog2(DIM_SIZE) : 1,
    parameter logic [DATA_W-1:0]  FILL     = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_in,
    output logic              ready_in,
    input  logic [DATA_W-1:0] value_in,
    input  logic [IDX_W-1:0]  index_in,
    output logic              valid_out,
    input  logic              ready_out,
    output logic [DATA_W-1:0] output_data,
    output logic [IDX_W-1:0]  out_idx,
    output logic              out_last,
    output logic              err_idx
);

    localparam logic [IDX_W-1:0] LAST_POS = IDX_W'(DIM_SIZE - 1);
    localparam logic [IDX_W:0]   DIM_EXT  = (IDX_W + 1)'(DIM_SIZE);

    typedef struct packed {
        logic [DATA_W-1:0] value;
        logic [IDX_W-1:0]  index;
        logic              bad;
    } rec_t;

    typedef enum logic {
        IDLE,
        EMIT
    } state_t;

    state_t           state, state_d;
    rec_t             fifo_mem [2];
    logic             wr_ptr, rd_ptr;
    logic [1:0]       fifo_cnt, fifo_cnt_d;
    logic             push, pop, in_bad;
    rec_t             head, row, row_d;
    logic [IDX_W-1:0] pos, pos_d;

    assign push       = valid_in && ready_in;
    assign in_bad     = {1'b0, index_in} >= DIM_EXT;
    assign head       = fifo_mem[rd_ptr];
    assign fifo_cnt_d = fifo_cnt + 2'(push) - 2'(pop);

    // Two-entry record queue; ready_in is registered from the next occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            fifo_cnt    <= 2'd0;
            ready_in    <= 1'b1;
            err_idx     <= 1'b0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= '{value: value_in, index: index_in, bad: in_bad};
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            fifo_cnt <= fifo_cnt_d;
            ready_in <= (fifo_cnt_d != 2'd2);
            err_idx  <= push && in_bad;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state: load a row from the queue head, walk positions on transfers
    always_comb begin
        state_d = state;
        pos_d   = pos;
        row_d   = row;
        pop     = 1'b0;
        case (state)
            IDLE: begin
                if (fifo_cnt != 2'd0) begin
                    pop     = 1'b1;
                    row_d   = head;
                    pos_d   = '0;
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (ready_out) begin
                    if (pos == LAST_POS) begin
                        pos_d = '0;
                        if (fifo_cnt != 2'd0) begin
                            pop   = 1'b1;
                            row_d = head;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        pos_d = pos + IDX_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Row registers and output stage, all driven from next-state values
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row         <= '0;
            pos         <= '0;
            valid_out   <= 1'b0;
            output_data <= FILL;
            out_idx     <= '0;
            out_last    <= 1'b0;
        end else begin
            row         <= row_d;
            pos         <= pos_d;
            valid_out   <= (state_d == EMIT);
            output_data <= ((state_d == EMIT) && (pos_d == row_d.index) && !row_d.bad)
                           ? row_d.value : FILL;
            out_idx     <= pos_d;
            out_last    <= (state_d == EMIT) && (pos_d == LAST_POS);
        end
    end

endmodule

// File: tb/tb_max_unpool_dim_scatter.sv
// Directed bench for max_unpool_dim_scatter: a 16-wide instance for row,
// back-to-back, backpressure and reset cases, a 12-wide one for bad indices.
module tb_max_unpool_dim_scatter;

    localparam int unsigned DIM   = 16;
    localparam int unsigned DIM_B = 12;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    logic        valid_in, ready_in, valid_out, ready_out, out_last, err_idx;
    logic [31:0] value_in, output_data;
    logic [3:0]  index_in, out_idx;

    logic        b_valid_in, b_ready_in, b_valid_out, b_ready_out, b_out_last, b_err_idx;
    logic [31:0] b_value_in, b_output_data;
    logic [3:0]  b_index_in, b_out_idx;

    max_unpool_dim_scatter #(.DATA_W(32), .DIM_SIZE(DIM), .FILL(32'h0)) u_dut (
        .clk(clk), .rst(rst),
        .valid_in(valid_in), .ready_in(ready_in), .value_in(value_in), .index_in(index_in),
        .valid_out(valid_out), .ready_out(ready_out), .output_data(output_data),
        .out_idx(out_idx), .out_last(out_last), .err_idx(err_idx)
    );

    max_unpool_dim_scatter #(.DATA_W(32), .DIM_SIZE(DIM_B), .FILL(32'h0)) u_dut_b (
        .clk(clk), .rst(rst),
        .valid_in(b_valid_in), .ready_in(b_ready_in), .value_in(b_value_in), .index_in(b_index_in),
        .valid_out(b_valid_out), .ready_out(b_ready_out), .output_data(b_output_data),
        .out_idx(b_out_idx), .out_last(b_out_last), .err_idx(b_err_idx)
    );

    int          n_vec = 0;
    int          n_bad = 0;
    int          first_cyc, last_cyc;
    logic [31:0] exp_val [$];
    int          exp_idx [$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge
    task automatic push(input logic [31:0] v, input logic [3:0] i);
        int t;
        t        = 0;
        valid_in = 1'b1;
        value_in = v;
        index_in = i;
        while (!ready_in && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!ready_in) check("push_timeout", 64'(ready_in), 64'd1);
        @(negedge clk);
        valid_in = 1'b0;
        exp_val.push_back(v);
        exp_idx.push_back(int'(i));
    endtask

    // Consumes n_rows rows, checking each element against the expected records
    task automatic drain(input int n_rows, input bit rnd);
        int          xfers, cyc, total, row, pos;
        bit          stalled;
        logic [36:0] held;
        logic [31:0] exp_d;
        xfers     = 0;
        cyc       = 0;
        total     = n_rows * DIM;
        stalled   = 1'b0;
        held      = '0;
        first_cyc = -1;
        last_cyc  = -1;
        while (xfers < total && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            if (stalled) begin
                check("hold_valid", 64'(valid_out), 64'd1);
                check("hold_bus", 64'({output_data, out_idx, out_last}), 64'(held));
            end
            ready_out = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            stalled   = 1'b0;
            if (valid_out) begin
                if (first_cyc < 0) first_cyc = cyc;
                if (ready_out) begin
                    row   = xfers / DIM;
                    pos   = xfers % DIM;
                    exp_d = (row < exp_idx.size() && pos == exp_idx[row]) ? exp_val[row] : 32'h0;
                    check("data", 64'(output_data), 64'(exp_d));
                    check("idx", 64'(out_idx), 64'(pos));
                    check("last", 64'(out_last), 64'(pos == DIM - 1));
                    xfers++;
                    last_cyc = cyc;
                end else begin
                    stalled = 1'b1;
                    held    = {output_data, out_idx, out_last};
                end
            end
        end
        check("drain_count", 64'(xfers), 64'(total));
        ready_out = 1'b1;
        exp_val.delete();
        exp_idx.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int k, cyc;
        valid_in    = 1'b0; value_in   = '0; index_in   = '0; ready_out   = 1'b1;
        b_valid_in  = 1'b0; b_value_in = '0; b_index_in = '0; b_ready_out = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_valid_out", 64'(valid_out), 64'd0);
        check("rst_ready_in", 64'(ready_in), 64'd1);
        check("rst_data", 64'(output_data), 64'd0);
        check("rst_idx", 64'(out_idx), 64'd0);
        check("rst_last", 64'(out_last), 64'd0);
        check("rst_err", 64'(err_idx), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single row, index 5
        push(32'h3F80_0000, 4'd5);
        check("lat_pre", 64'(valid_out), 64'd0);
        drain(1, 1'b0);
        check("lat_first", 64'(first_cyc), 64'd1);
        check("contig1", 64'(last_cyc - first_cyc + 1), 64'(DIM));
        @(negedge clk);
        check("idle1", 64'(valid_out), 64'd0);

        // Back-to-back rows: indices 0, 15, 7
        fork
            begin
                push(32'hAAAA_0001, 4'd0);
                push(32'hBBBB_0002, 4'd15);
                push(32'hCCCC_0003, 4'd7);
                check("rdy_drop", 64'(ready_in), 64'd0);
            end
            drain(3, 1'b0);
        join
        check("contig3", 64'(last_cyc - first_cyc + 1), 64'(3 * DIM));
        check("rdy_back", 64'(ready_in), 64'd1);
        @(negedge clk);
        check("idle2", 64'(valid_out), 64'd0);

        // Random backpressure over four rows
        fork
            begin
                push(32'h1111_1111, 4'd3);
                push(32'h2222_2222, 4'd9);
                push(32'h3333_3333, 4'd14);
                push(32'h4444_4444, 4'd0);
            end
            drain(4, 1'b1);
        join
        @(negedge clk);
        check("idle3", 64'(valid_out), 64'd0);

        // Bad index on the 12-wide instance
        b_valid_in = 1'b1;
        b_index_in = 4'd13;
        b_value_in = 32'hCAFE_F00D;
        @(negedge clk);
        b_valid_in = 1'b0;
        check("err_pulse", 64'(b_err_idx), 64'd1);
        k   = 0;
        cyc = 0;
        while (k < DIM_B && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) check("err_clear", 64'(b_err_idx), 64'd0);
            if (b_valid_out) begin
                check("bad_data", 64'(b_output_data), 64'd0);
                check("bad_idx", 64'(b_out_idx), 64'(k));
                check("bad_last", 64'(b_out_last), 64'(k == DIM_B - 1));
                k++;
            end
        end
        check("bad_count", 64'(k), 64'(DIM_B));
        @(negedge clk);
        check("bad_idle", 64'(b_valid_out), 64'd0);

        // Reset at position 6 with one record queued
        push(32'h4040_0000, 4'd2);
        push(32'h5050_0000, 4'd9);
        exp_val.delete();
        exp_idx.delete();
        cyc = 0;
        while (!(valid_out && out_idx == 4'd6) && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("reach_pos6", 64'(out_idx), 64'd6);
        rst = 1'b1;
        #1;
        check("arst_valid_out", 64'(valid_out), 64'd0);
        check("arst_ready_in", 64'(ready_in), 64'd1);
        check("arst_data", 64'(output_data), 64'd0);
        check("arst_idx", 64'(out_idx), 64'd0);
        check("arst_last", 64'(out_last), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("no_stale_row", 64'(valid_out), 64'd0);
        end
        push(32'h6060_0000, 4'd4);
        drain(1, 1'b0);
        check("post_rst_lat", 64'(first_cyc), 64'd1);
        @(negedge clk);
        check("idle4", 64'(valid_out), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
